// File: rtl/osd_spi_tx_pkg.sv
// rtl/osd_spi_tx_pkg.sv - OSD command link constants, command encodings and FSM states
package osd_spi_tx_pkg;

  // Byte values shared with the OSD receiver
  localparam logic [7:0] OSD_CMD_DISABLE = 8'h40;
  localparam logic [7:0] OSD_CMD_ENABLE  = 8'h41;
  localparam logic [7:0] OSD_CMD_WRITE   = 8'h20;
  localparam int         OSD_LINE_BYTES  = 256;

  localparam logic [1:0] CMD_TYPE_DISABLE = 2'd0;
  localparam logic [1:0] CMD_TYPE_ENABLE  = 2'd1;
  localparam logic [1:0] CMD_TYPE_WRITE   = 2'd2;
  localparam logic [1:0] CMD_TYPE_RSVD    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  function automatic logic [7:0] osd_cmd_byte(input logic [1:0] ctype, input logic [2:0] line);
    logic [7:0] b;
    b = 8'h00;
    case (ctype)
      CMD_TYPE_DISABLE: b = OSD_CMD_DISABLE;
      CMD_TYPE_ENABLE:  b = OSD_CMD_ENABLE;
      CMD_TYPE_WRITE:   b = OSD_CMD_WRITE | {5'b00000, line};
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/osd_spi_tx_clkgen.sv
// rtl/osd_spi_tx_clkgen.sv - SCK divider with rise/fall/low-phase-end strobes
module osd_spi_tx_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic run,
  input  logic hold_low,
  output logic spi_sck,
  output logic rise_en,
  output logic fall_en,
  output logic low_end
);

  localparam int            CW     = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc      = run && (cnt == CNT_TC);
  // hold_low lets a low phase complete without starting another SCK pulse
  assign rise_en = tc && !spi_sck && !hold_low;
  assign fall_en = tc && spi_sck;
  assign low_end = tc && !spi_sck;

  always_ff @(posedge clk_sys) begin
    if (!reset_n || !run) begin
      cnt     <= '0;
      spi_sck <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (rise_en) begin
        spi_sck <= 1'b1;
      end else if (fall_en) begin
        spi_sck <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/osd_spi_tx.sv
// rtl/osd_spi_tx.sv - SPI master framing OSD enable/disable/line-write commands on SS3
module osd_spi_tx
  import osd_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [2:0] cmd_line,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       spi_sck,
  output logic       spi_ss3,
  output logic       spi_di
);

  localparam int            GW        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_TC    = GW'(GAP_CYC - 1);
  localparam logic [8:0]    LAST_BYTE = 9'(OSD_LINE_BYTES);

  state_e        state;
  state_e        state_nxt;
  logic          ready_q;
  logic          accept;
  logic          run;
  logic          hold_low;
  logic          gap_done;
  logic          rise_en;
  logic          fall_en;
  logic          low_end;
  logic [7:0]    shreg;
  logic [7:0]    stage;
  logic [2:0]    bit_cnt;
  logic [8:0]    byte_cnt;
  logic          is_write;
  logic          frame_last;
  logic          cap_q;
  logic          rsv_done;
  logic [GW-1:0] gap_cnt;

  assign accept = cmd_valid && cmd_ready;
  assign spi_di = shreg[7];
  assign done   = rsv_done || gap_done;

  osd_spi_tx_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .run      (run),
    .hold_low (hold_low),
    .spi_sck  (spi_sck),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .low_end  (low_end)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    run       = 1'b0;
    hold_low  = 1'b0;
    gap_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = ready_q;
        if (accept && (cmd_type != CMD_TYPE_RSVD)) begin
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        run = 1'b1;
        if (rise_en) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        run      = 1'b1;
        hold_low = frame_last;
        if (frame_last && low_end) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        run      = 1'b1;
        hold_low = 1'b1;
        if (low_end) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_TC) begin
          gap_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      spi_ss3    <= 1'b1;
      shreg      <= 8'h00;
      stage      <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 9'd0;
      is_write   <= 1'b0;
      frame_last <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= 8'h00;
      cap_q      <= 1'b0;
      rsv_done   <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      ready_q  <= 1'b1;
      rd_en    <= 1'b0;
      cap_q    <= rd_en;
      rsv_done <= 1'b0;
      if (cap_q) begin
        stage <= rd_data;
      end
      if (rd_en && (rd_addr != 8'hFF)) begin
        rd_addr <= rd_addr + 8'd1;
      end

      if (accept) begin
        if (cmd_type == CMD_TYPE_RSVD) begin
          rsv_done <= 1'b1;
        end else begin
          spi_ss3    <= 1'b0;
          shreg      <= osd_cmd_byte(cmd_type, cmd_line);
          is_write   <= (cmd_type == CMD_TYPE_WRITE);
          bit_cnt    <= 3'd0;
          byte_cnt   <= 9'd0;
          frame_last <= 1'b0;
          rd_addr    <= 8'h00;
        end
      end

      if (state == ST_SHIFT) begin
        // Fetch the next byte early in the current one so the staging reg is full by bit 7
        if (rise_en && is_write && (bit_cnt == 3'd1) && (byte_cnt != LAST_BYTE)) begin
          rd_en <= 1'b1;
        end
        if (fall_en) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt <= 3'd0;
            if (is_write && (byte_cnt != LAST_BYTE)) begin
              shreg    <= stage;
              byte_cnt <= byte_cnt + 9'd1;
            end else begin
              shreg      <= 8'h00;
              frame_last <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
          end
        end
      end

      if ((state == ST_HOLD) && low_end) begin
        spi_ss3    <= 1'b1;
        frame_last <= 1'b0;
        gap_cnt    <= '0;
      end

      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule
